switch_port_receiver: RTL and testbench
=======================================

// Module: switch_port_receiver
// PURPOSE
//  - Output-side endpoint for one 8-bit lane of the 4-port switch.
//  - Consumes the lane's rcv_rdy/valid_out/addr_out/data_out and produces its data_rd bit.
//  - Instantiate once per lane (x4). Lane k uses bits [8k+7:8k] of addr_out/data_out and bit k of the others.
//  - Buffers received {addr,data} pairs in a local FIFO for downstream logic.
// PARAMETERS
//  AW       8   lane address width (bits)
//  DW       8   lane data width (bits)
//  DEPTH    8   FIFO entries; power of 2, >=2
//  TIMEOUT  4   max cycles in WAIT for valid_out before abort; >=1
//  PORT_ID  0   this lane's index (0..3); used only with RCV_ADDR_CHECK_EN
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  reset        in   1              synchronous, active-high
//  rcv_rdy      in   1              switch has a packet pending for this lane
//  valid_out    in   1              switch presents addr_out/data_out this cycle
//  addr_out     in   AW             packet address from switch
//  data_out     in   DW             packet data from switch
//  data_rd      out  1              read request to switch (one-cycle pulse)
//  pop          in   1              downstream consumes FIFO head
//  pkt_valid    out  1              FIFO non-empty; head visible on pkt_addr/pkt_data
//  pkt_addr     out  AW             FIFO head address (first-word fall-through)
//  pkt_data     out  DW             FIFO head data
//  fifo_count   out  $clog2(DEPTH)+1  entries held
//  timeout_err  out  1              one-cycle pulse: WAIT expired without valid_out
//  spurious_err out  1              one-cycle pulse: valid_out seen outside WAIT
//  misroute_err out  1              one-cycle pulse: address mismatch (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE.
//    - All outputs 0: data_rd, pkt_valid, pkt_addr, pkt_data, fifo_count and all *_err.
//    - FIFO pointers cleared; any buffered or in-flight packet is discarded.
//    - Reset asserted mid-WAIT aborts the transfer. A valid_out arriving after reset releases is
//      spurious (spurious_err pulses).
//  - FSM, one transfer outstanding at a time:
//    - IDLE -> REQ when rcv_rdy==1 && fifo_count<DEPTH; otherwise stay in IDLE.
//    - REQ: data_rd=1 for exactly this cycle; always -> WAIT, timer=0.
//    - WAIT: data_rd=0.
//      - valid_out==1: capture {addr_out,data_out}, push to FIFO, -> IDLE.
//      - else timer==TIMEOUT-1: pulse timeout_err, nothing pushed, -> IDLE.
//      - else timer++.
//  - Timing:
//    - valid_out is legal from the cycle after data_rd through TIMEOUT cycles after it.
//    - Minimum turnaround is 3 cycles per packet (REQ, WAIT, IDLE).
//    - Push to pkt_valid latency is 1 cycle (data is registered into the FIFO).
//  - valid_out in IDLE or REQ: ignored (no push) and spurious_err pulses.
//  - FIFO space is checked before data_rd, so an overflow cannot occur.
//  - pop with pkt_valid==0: ignored, no state change.
//  - Same-cycle push and pop:
//    - Both take effect and fifo_count is unchanged.
//    - When empty, the pushed entry appears on the next cycle.
//  - Pointers wrap modulo DEPTH.
//  - fifo_count==DEPTH blocks new requests even while rcv_rdy stays high.
//  - A pop while full frees the slot; IDLE->REQ may occur the cycle after the pop.
// CONFIGURATION
//  RCV_ADDR_CHECK_EN defined:
//    - A captured packet with addr_out != PORT_ID (zero-extended to AW) is not pushed.
//    - misroute_err pulses in the capture cycle.
//    - FSM still returns to IDLE.
//  RCV_ADDR_CHECK_EN undefined:
//    - Every captured packet is pushed.
//    - misroute_err is tied 0.
// TESTING
//  1. Reset, rcv_rdy=1.
//     -> data_rd pulses 1 cycle.
//     -> valid_out next cycle with addr=8'h00, data=8'hA5: pkt_valid=1 one cycle later, pkt_data=8'hA5, fifo_count=1.
//  2. data_rd issued, valid_out withheld for 4 cycles (TIMEOUT=4).
//     -> timeout_err pulses in the 4th WAIT cycle, fifo_count unchanged, FSM back in IDLE.
//  3. rcv_rdy held high, pop=0, 8 packets 8'h01..8'h08.
//     -> fifo_count=8, data_rd no longer pulses.
//     -> single pop: pkt_data 8'h01->8'h02, a new data_rd follows.
//  4. fifo_count=1, push of 8'h55 and pop in the same cycle.
//     -> fifo_count stays 1, head becomes 8'h55.
//  5. valid_out asserted while in IDLE.
//     -> spurious_err pulses, fifo_count unchanged.
//  6. RCV_ADDR_CHECK_EN, PORT_ID=2, packet addr=8'h01.
//     -> misroute_err pulses, no push. addr=8'h02 -> pushed.

Source files
------------

// File: rtl/switch_port_receiver.sv
// Receive endpoint for one switch output lane: requests, captures and buffers {addr,data}.
// Optional build macro RCV_ADDR_CHECK_EN drops packets whose address differs from PORT_ID.
module switch_port_receiver #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4,
    parameter int PORT_ID = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rcv_rdy,
    input  logic                       valid_out,
    input  logic [AW-1:0]              addr_out,
    input  logic [DW-1:0]              data_out,
    output logic                       data_rd,
    input  logic                       pop,
    output logic                       pkt_valid,
    output logic [AW-1:0]              pkt_addr,
    output logic [DW-1:0]              pkt_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       timeout_err,
    output logic                       spurious_err,
    output logic                       misroute_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     timer;
    logic              timer_done;
    logic [AW+DW-1:0]  mem [DEPTH];
    logic [AW+DW-1:0]  head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              has_space;
    logic              capture;
    logic              addr_ok;
    logic              push;
    logic              do_pop;

    assign has_space  = count < CW'(DEPTH);
    assign timer_done = timer == TW'(TIMEOUT - 1);
    assign capture    = (state == WAIT) && valid_out;
    assign push       = capture && addr_ok;
    assign do_pop     = pop && (count != '0);

`ifdef RCV_ADDR_CHECK_EN
    assign addr_ok      = addr_out == AW'(PORT_ID);
    assign misroute_err = !reset && capture && !addr_ok;
`else
    assign addr_ok      = 1'b1;
    assign misroute_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (rcv_rdy && has_space) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (valid_out || timer_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic; pulses are suppressed while reset is held
    always_comb begin
        data_rd      = 1'b0;
        timeout_err  = 1'b0;
        spurious_err = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    spurious_err = valid_out;
                end
                REQ: begin
                    data_rd      = 1'b1;
                    spurious_err = valid_out;
                end
                WAIT: begin
                    timeout_err = !valid_out && timer_done;
                end
                default: begin
                    spurious_err = valid_out;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (state == REQ) begin
            timer <= '0;
        end else if (state == WAIT && !timer_done) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {addr_out, data_out};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head is masked when empty so stale storage never leaks out
    assign head       = mem[rd_ptr];
    assign pkt_valid  = count != '0;
    assign pkt_addr   = pkt_valid ? head[AW+DW-1:DW] : '0;
    assign pkt_data   = pkt_valid ? head[DW-1:0] : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_switch_port_receiver.sv
// Bench for switch_port_receiver: directed table, corner sequences, random vs queue model.
// Build with RCV_ADDR_CHECK_EN defined to exercise the address filter (PORT_ID=2).
module tb_switch_port_receiver;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int TMO   = 4;
`ifdef RCV_ADDR_CHECK_EN
    localparam int PID = 2;
`else
    localparam int PID = 0;
`endif
    localparam logic [7:0] PA = 8'(PID);

    logic       clk = 1'b0;
    logic       reset;
    logic       rcv_rdy;
    logic       valid_out;
    logic [7:0] addr_out;
    logic [7:0] data_out;
    logic       data_rd;
    logic       pop;
    logic       pkt_valid;
    logic [7:0] pkt_addr;
    logic [7:0] pkt_data;
    logic [3:0] fifo_count;
    logic       timeout_err;
    logic       spurious_err;
    logic       misroute_err;

    switch_port_receiver #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .PORT_ID(PID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rcv_rdy(rcv_rdy),
        .valid_out(valid_out),
        .addr_out(addr_out),
        .data_out(data_out),
        .data_rd(data_rd),
        .pop(pop),
        .pkt_valid(pkt_valid),
        .pkt_addr(pkt_addr),
        .pkt_data(pkt_data),
        .fifo_count(fifo_count),
        .timeout_err(timeout_err),
        .spurious_err(spurious_err),
        .misroute_err(misroute_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase of the one outstanding transfer plus a packet queue
    int          m_phase = 0;
    int          m_age   = 0;
    logic [15:0] q[$];

    logic       s_rd, s_pv, s_tmo, s_spur, s_mis;
    logic [7:0] s_addr, s_data;
    logic [3:0] s_cnt;

    task automatic model_cycle(input logic r, rdy, v, input logic [7:0] a, d, input logic p);
        logic match;
        logic e_mis;
        int   sz;
`ifdef RCV_ADDR_CHECK_EN
        match = (a == PA);
        e_mis = !r && m_phase == 2 && v && !match;
`else
        match = 1'b1;
        e_mis = 1'b0;
`endif
        chk("m_rd", 32'(s_rd), 32'(!r && m_phase == 1));
        chk("m_spur", 32'(s_spur), 32'(!r && v && m_phase != 2));
        chk("m_tmo", 32'(s_tmo), 32'(!r && m_phase == 2 && !v && m_age == TMO - 1));
        chk("m_mis", 32'(s_mis), 32'(e_mis));
        chk("m_pv", 32'(s_pv), 32'(q.size() > 0));
        chk("m_cnt", 32'(s_cnt), 32'(q.size()));
        chk("m_addr", 32'(s_addr), q.size() > 0 ? 32'(q[0][15:8]) : 32'd0);
        chk("m_data", 32'(s_data), q.size() > 0 ? 32'(q[0][7:0]) : 32'd0);
        sz = q.size();
        if (r) begin
            q.delete();
            m_phase = 0;
            m_age   = 0;
        end else begin
            if (p && sz > 0) void'(q.pop_front());
            if (m_phase == 0) begin
                if (rdy && sz < DEPTH) m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_age   = 0;
            end else begin
                if (v) begin
                    if (match) q.push_back({a, d});
                    m_phase = 0;
                end else if (m_age == TMO - 1) begin
                    m_phase = 0;
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    // One clock: drive, sample away from the edge, check model, advance
    task automatic cyc(input logic r, rdy, v, input logic [7:0] a, d, input logic p);
        reset = r; rcv_rdy = rdy; valid_out = v;
        addr_out = a; data_out = d; pop = p;
        @(negedge clk);
        s_rd = data_rd; s_pv = pkt_valid; s_tmo = timeout_err;
        s_spur = spurious_err; s_mis = misroute_err;
        s_addr = pkt_addr; s_data = pkt_data; s_cnt = fifo_count;
        model_cycle(r, rdy, v, a, d, p);
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] a, d);
        cyc(0, 1, 0, PA, 0, 0);
        cyc(0, 0, 0, PA, 0, 0);
        chk("xfer_rd", 32'(s_rd), 1);
        cyc(0, 0, 1, a, d, 0);
    endtask

    typedef struct {
        logic       r, rdy, v;
        logic [7:0] d;
        logic       p;
        logic       e_rd, e_pv;
        logic [7:0] e_data;
        logic [3:0] e_cnt;
        logic       e_tmo, e_spur;
    } vec_t;

    function automatic vec_t mk(input logic r, rdy, v, input logic [7:0] d, input logic p,
                                input logic e_rd, e_pv, input logic [7:0] e_data,
                                input logic [3:0] e_cnt, input logic e_tmo, e_spur);
        vec_t t;
        t.r = r; t.rdy = rdy; t.v = v; t.d = d; t.p = p;
        t.e_rd = e_rd; t.e_pv = e_pv; t.e_data = e_data;
        t.e_cnt = e_cnt; t.e_tmo = e_tmo; t.e_spur = e_spur;
        return t;
    endfunction

    vec_t tbl[14];

    initial begin
        int         k;
        int         delay;
        logic       lastrd;
        logic       r, rdy, v, p;
        logic [7:0] a;

        //              r rdy v d     p  rd pv data  cnt tmo sp
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 1, 0);
        tbl[10] = mk(0, 0, 1, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 8'h00, 1, 0, 1, 8'hA5, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

        reset = 1; rcv_rdy = 0; valid_out = 0;
        addr_out = 0; data_out = 0; pop = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].rdy, tbl[i].v, PA, tbl[i].d, tbl[i].p);
            chk($sformatf("tbl%0d_rd", i), 32'(s_rd), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_pv", i), 32'(s_pv), 32'(tbl[i].e_pv));
            chk($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_cnt", i), 32'(s_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_tmo", i), 32'(s_tmo), 32'(tbl[i].e_tmo));
            chk($sformatf("tbl%0d_spur", i), 32'(s_spur), 32'(tbl[i].e_spur));
        end

        // Fill to DEPTH with rcv_rdy held, then verify blocking and refill after a pop
        cyc(1, 0, 0, PA, 0, 0);
        k = 0;
        lastrd = 0;
        for (int n = 0; n < 30 && k < 8; n++) begin
            cyc(0, 1, lastrd, PA, 8'(k + 1), 0);
            if (lastrd) k++;
            lastrd = s_rd;
        end
        chk("fill_done", 32'(k), 8);
        for (int n = 0; n < 4; n++) begin
            cyc(0, 1, 0, PA, 0, 0);
            chk("full_no_rd", 32'(s_rd), 0);
        end
        chk("full_cnt", 32'(s_cnt), 8);
        cyc(0, 1, 0, PA, 0, 1);
        chk("pop_head_old", 32'(s_data), 8'h01);
        cyc(0, 1, 0, PA, 0, 0);
        chk("pop_head_new", 32'(s_data), 8'h02);
        chk("pop_cnt", 32'(s_cnt), 7);
        cyc(0, 1, 0, PA, 0, 0);
        chk("refill_rd", 32'(s_rd), 1);
        cyc(0, 0, 1, PA, 8'h09, 0);

        // Push and pop in the same cycle with one entry held
        cyc(1, 0, 0, PA, 0, 0);
        xfer(PA, 8'h33);
        cyc(0, 1, 0, PA, 0, 0);
        chk("pp_head", 32'(s_data), 8'h33);
        cyc(0, 0, 0, PA, 0, 0);
        chk("pp_rd", 32'(s_rd), 1);
        cyc(0, 0, 1, PA, 8'h55, 1);
        cyc(0, 0, 0, PA, 0, 0);
        chk("pp_cnt", 32'(s_cnt), 1);
        chk("pp_data", 32'(s_data), 8'h55);

`ifdef RCV_ADDR_CHECK_EN
        cyc(1, 0, 0, PA, 0, 0);
        xfer(8'h01, 8'h66);
        chk("mis_pulse", 32'(s_mis), 1);
        cyc(0, 0, 0, PA, 0, 0);
        chk("mis_nopush", 32'(s_cnt), 0);
        xfer(8'h02, 8'h77);
        chk("ok_nopulse", 32'(s_mis), 0);
        cyc(0, 0, 0, PA, 0, 0);
        chk("ok_cnt", 32'(s_cnt), 1);
        chk("ok_data", 32'(s_data), 8'h77);
`endif

        // Random traffic against the model
        cyc(1, 0, 0, PA, 0, 0);
        delay = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            v   = (delay == 1) || ($urandom_range(0, 19) == 0);
            a   = ($urandom_range(0, 3) != 0) ? PA : 8'($urandom_range(0, 255));
            if (i < 1000) p = ($urandom_range(0, 5) == 0);
            else          p = ($urandom_range(0, 1) == 0);
            cyc(r, rdy, v, a, 8'($urandom_range(0, 255)), p);
            if (s_rd)           delay = $urandom_range(1, 5);
            else if (delay > 0) delay--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
